// File: rtl/control_path1.sv
// Multi-cycle MIPS32 controller: fetches IR, decodes it and walks
// IF -> ID -> EX -> [MEM] -> [WB], driving ALU opcode, mux selects, strobes
// and PC enable. Also sequences reset, halts on HLT/illegal opcode and
// counts retired instructions.
module control_path1 #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [31:0]      ir_i,
  input  logic             eqz_i,
  output logic [5:0]       opcode_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [4:0]       rd_o,
  output logic             sel1_o,
  output logic             sel2_o,
  output logic             sel3_o,
  output logic             sel4_o,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  output logic             reg_wr_o,
  output logic             clr_pc_o,
  output logic             pc_en_o,
  output logic             halted_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int RC_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;

  // decode of the latched instruction
  logic [5:0] op;
  logic       is_rr, is_lw, is_sw, is_ri, is_br, is_beqz, is_hlt, legal;
  logic       taken, show_dec;
  logic [5:0] alu_op;
  logic       unused_imm;

  // immediate field is consumed by the data path, not here
  assign unused_imm = ^ir_q[10:0];

  // Instruction class and ALU opcode from the latched IR
  always_comb begin
    op      = ir_q[31:26];
    is_rr   = (op <= 6'h05);
    is_lw   = (op == 6'h08);
    is_sw   = (op == 6'h09);
    is_ri   = (op == 6'h0A) || (op == 6'h0B) || (op == 6'h0C);
    is_br   = (op == 6'h0D) || (op == 6'h0E);
    is_beqz = (op == 6'h0E);
    is_hlt  = (op == 6'h3F);
    legal   = is_rr || is_lw || is_sw || is_ri || is_br || is_hlt;
    taken   = is_beqz ? eqz_i : ~eqz_i;
    alu_op  = 6'h00;
    if (is_rr)            alu_op = op;
    else if (op == 6'h0B) alu_op = 6'h01;
    else if (op == 6'h0C) alu_op = 6'h04;
  end

  // State and bookkeeping registers; reset abandons any instruction in flight
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_RST;
      rst_cnt_q <= '0;
      ir_q      <= '0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and output decode; strobes are raised only in their own state
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;

    opcode_o  = 6'h00;
    rs1_o     = 5'd0;
    rs2_o     = 5'd0;
    rd_o      = 5'd0;
    sel1_o    = 1'b1;
    sel2_o    = 1'b0;
    sel3_o    = 1'b0;
    sel4_o    = 1'b1;
    mem_rd_o  = 1'b0;
    mem_wr_o  = 1'b0;
    reg_wr_o  = 1'b0;
    clr_pc_o  = 1'b0;
    pc_en_o   = 1'b0;

    // decoded controls are held steady from ID through the final cycle
    show_dec = ((state_q == S_ID) || (state_q == S_EX) ||
                (state_q == S_MEM) || (state_q == S_WB)) && legal && !is_hlt;
    if (show_dec) begin
      opcode_o = alu_op;
      rs1_o    = ir_q[25:21];
      rs2_o    = ir_q[20:16];
      rd_o     = is_rr ? ir_q[15:11] : ir_q[20:16];
      sel1_o   = ~is_br;
      sel2_o   = ~is_rr;
      sel4_o   = ~is_lw;
    end

    case (state_q)
      S_RST: begin
        clr_pc_o = 1'b1;
        // counts cycles with rst_n high; leaves after RST_CYCLES of them
        if (rst_cnt_q >= RC_W'(RST_CYCLES)) state_d = S_IF;
        else rst_cnt_d = rst_cnt_q + RC_W'(1);
      end
      S_IF: begin
        ir_d    = ir_i;
        state_d = S_ID;
      end
      S_ID: begin
        if (is_hlt || !legal) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = !legal;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_br) begin
          sel3_o  = taken;
          pc_en_o = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_IF;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          mem_wr_o = 1'b1;
          pc_en_o  = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = S_IF;
        end else begin
          mem_rd_o = 1'b1;
          state_d  = S_WB;
        end
      end
      S_WB: begin
        mem_rd_o = is_lw;
        reg_wr_o = 1'b1;
        pc_en_o  = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = S_IF;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  assign halted_o    = halted_q;
  assign illegal_o   = illegal_q;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_control_path1.sv
// Bench for control_path1: a per-instruction step model predicts every
// output each cycle; directed programs add hand-computed strobe tallies.
module tb_control_path1;

  localparam int RSTC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        EQZ = 1'b0;

  logic [5:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        sel1, sel2, sel3, sel4, mem_rd, mem_wr, reg_wr, clr_pc, pc_en;
  logic        halted, illegal;
  logic [15:0] instr_cnt;

  // narrow-counter twin, used only for its wrap behaviour
  logic [5:0]  w_opcode;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic        w_sel1, w_sel2, w_sel3, w_sel4, w_mem_rd, w_mem_wr, w_reg_wr;
  logic        w_clr_pc, w_pc_en, w_halted, w_illegal;
  logic [2:0]  w_cnt;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  control_path1 #(.RST_CYCLES(RSTC), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ir_i(IR), .eqz_i(EQZ),
    .opcode_o(opcode), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd),
    .sel1_o(sel1), .sel2_o(sel2), .sel3_o(sel3), .sel4_o(sel4),
    .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .reg_wr_o(reg_wr),
    .clr_pc_o(clr_pc), .pc_en_o(pc_en), .halted_o(halted),
    .illegal_o(illegal), .instr_cnt_o(instr_cnt)
  );

  control_path1 #(.RST_CYCLES(RSTC), .CNT_W(3)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .ir_i(IR), .eqz_i(EQZ),
    .opcode_o(w_opcode), .rs1_o(w_rs1), .rs2_o(w_rs2), .rd_o(w_rd),
    .sel1_o(w_sel1), .sel2_o(w_sel2), .sel3_o(w_sel3), .sel4_o(w_sel4),
    .mem_rd_o(w_mem_rd), .mem_wr_o(w_mem_wr), .reg_wr_o(w_reg_wr),
    .clr_pc_o(w_clr_pc), .pc_en_o(w_pc_en), .halted_o(w_halted),
    .illegal_o(w_illegal), .instr_cnt_o(w_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // cycles an instruction occupies, 0 for anything that does not retire
  function automatic int latency(input logic [5:0] op);
    if (op <= 6'h05) return 4;
    if (op == 6'h08) return 5;
    if (op == 6'h09) return 4;
    if (op >= 6'h0A && op <= 6'h0C) return 4;
    if (op == 6'h0D || op == 6'h0E) return 3;
    return 0;
  endfunction

  // model: reset phase counter, current word and its 1-based cycle index
  bit          m_rst = 1'b1;
  int          m_r = 0;
  logic [31:0] m_w = 32'h0;
  int          m_k = 0;
  bit          m_halt = 1'b0, m_ill = 1'b0;
  logic [15:0] m_cnt = 16'h0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rst <= 1'b1; m_r <= 0; m_k <= 0; m_w <= 32'h0;
      m_halt <= 1'b0; m_ill <= 1'b0; m_cnt <= 16'h0;
    end else if (m_rst) begin
      m_r <= m_r + 1;
      if (m_r + 1 > RSTC) begin m_rst <= 1'b0; m_k <= 1; end
    end else if (!m_halt) begin
      if (m_k == 1) begin
        m_w <= IR; m_k <= 2;
      end else if (m_k == 2 && latency(m_w[31:26]) == 0) begin
        m_halt <= 1'b1; m_ill <= (m_w[31:26] != 6'h3F);
      end else if (m_k == latency(m_w[31:26])) begin
        m_cnt <= m_cnt + 16'd1; m_k <= 1;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  logic [5:0] e_op, e_opc;
  logic [4:0] e_rs1, e_rs2, e_rd;
  logic       e_s1, e_s2, e_s3, e_s4, e_mr, e_mw, e_rw, e_pc, e_dec;
  int         e_l;

  // every-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      e_op  = m_w[31:26];
      e_l   = latency(e_op);
      e_dec = !m_rst && !m_halt && m_k >= 2 && e_l != 0;
      e_opc = 6'h0; e_rs1 = 5'd0; e_rs2 = 5'd0; e_rd = 5'd0;
      e_s1 = 1'b1; e_s2 = 1'b0; e_s3 = 1'b0; e_s4 = 1'b1;
      e_mr = 1'b0; e_mw = 1'b0; e_rw = 1'b0; e_pc = 1'b0;
      if (e_dec) begin
        e_opc = (e_op <= 6'h05) ? e_op : (e_op == 6'h0B) ? 6'h01 : (e_op == 6'h0C) ? 6'h04 : 6'h00;
        e_rs1 = m_w[25:21];
        e_rs2 = m_w[20:16];
        e_rd  = (e_op <= 6'h05) ? m_w[15:11] : m_w[20:16];
        e_s1  = !(e_l == 3);
        e_s2  = !(e_op <= 6'h05);
        e_s4  = !(e_op == 6'h08);
        e_mr  = (e_op == 6'h08) && m_k >= 4;
        e_mw  = (e_op == 6'h09) && m_k == 4;
        e_pc  = (m_k == e_l);
        e_rw  = e_pc && e_op != 6'h09 && e_l != 3;
        e_s3  = (e_l == 3) && m_k == 3 && ((e_op == 6'h0E) ? EQZ : !EQZ);
      end
      chk("cycle outputs",
          {clr_pc, pc_en, mem_rd, mem_wr, reg_wr, sel1, sel2, sel3, sel4, halted, illegal,
           opcode, rs1, rs2, rd, instr_cnt},
          {m_rst, e_pc, e_mr, e_mw, e_rw, e_s1, e_s2, e_s3, e_s4, m_halt, m_ill,
           e_opc, e_rs1, e_rs2, e_rd, m_cnt});
      chk("narrow counter", {61'd0, w_cnt}, {61'd0, m_cnt[2:0]});
    end
  end

  // holds rst_n low for nlow edges, then tallies clr_PC cycles after release
  task automatic do_reset(input int nlow);
    int n;
    rst_n = 1'b0;
    repeat (nlow) begin @(posedge clk); #1; end
    cmp_en = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n = 0;
    repeat (RSTC) begin @(negedge clk); n += int'(clr_pc); @(posedge clk); #1; end
    chk("reset clr_PC cycles", n, RSTC);
    chk("reset instr_cnt", instr_cnt, 0);
  endtask

  // presents one instruction from its IF cycle, tallies strobe cycles
  task automatic run_instr(input string nm, input logic [31:0] w, input logic e, input int cyc,
                           input int x_pc, input int x_rw, input int x_mr, input int x_mw,
                           input int x_s3);
    int pc, rw, mr, mw, s3;
    pc = 0; rw = 0; mr = 0; mw = 0; s3 = 0;
    IR = w; EQZ = e;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      pc += int'(pc_en); rw += int'(reg_wr); mr += int'(mem_rd);
      mw += int'(mem_wr); s3 += int'(sel3);
      @(posedge clk); #1;
    end
    chk(nm, {8'(pc), 8'(rw), 8'(mr), 8'(mw), 8'(s3)},
            {8'(x_pc), 8'(x_rw), 8'(x_mr), 8'(x_mw), 8'(x_s3)});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    run_instr("ADD",       32'h00221800, 1'b0, 4, 1, 1, 0, 0, 0);
    chk("count after ADD", instr_cnt, 16'd1);
    run_instr("LW",        32'h20220004, 1'b0, 5, 1, 1, 2, 0, 0);
    run_instr("SW",        32'h24220004, 1'b0, 4, 1, 0, 0, 1, 0);
    run_instr("BEQZ eqz1", 32'h38200005, 1'b1, 3, 1, 0, 0, 0, 1);
    run_instr("BEQZ eqz0", 32'h38200005, 1'b0, 3, 1, 0, 0, 0, 0);
    run_instr("BNEQZ eqz0",32'h34200005, 1'b0, 3, 1, 0, 0, 0, 1);
    run_instr("BNEQZ eqz1",32'h34200005, 1'b1, 3, 1, 0, 0, 0, 0);
    run_instr("SUBI",      32'h2C220003, 1'b0, 4, 1, 1, 0, 0, 0);
    run_instr("MUL",       32'h14221800, 1'b0, 4, 1, 1, 0, 0, 0);
    chk("count after program", instr_cnt, 16'd9);
    run_instr("HLT",       32'hFC000000, 1'b0, 5, 0, 0, 0, 0, 0);
    chk("HLT flags", {halted, illegal, instr_cnt}, {1'b1, 1'b0, 16'd9});

    do_reset(3);
    run_instr("illegal op",32'h40000000, 1'b0, 4, 0, 0, 0, 0, 0);
    chk("illegal flags", {halted, illegal}, 2'b11);

    // reset while a load sits in MEM: nothing further commits
    do_reset(2);
    run_instr("ADD pre",   32'h00221800, 1'b0, 4, 1, 1, 0, 0, 0);
    IR = 32'h20220004;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("LW in MEM", {mem_rd, reg_wr, pc_en}, 3'b100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort into RST", {clr_pc, reg_wr, pc_en, mem_rd, instr_cnt}, {4'b1000, 16'd0});
    do_reset(1);

    // narrow counter wraps 7 -> 0
    for (int i = 0; i < 8; i++)
      run_instr("ADD wrap", 32'h00221800, 1'b0, 4, 1, 1, 0, 0, 0);
    chk("wrap main count", instr_cnt, 16'd8);
    chk("wrap narrow count", w_cnt, 3'd0);
    run_instr("ADD wrap", 32'h00221800, 1'b0, 4, 1, 1, 0, 0, 0);
    chk("after wrap narrow", w_cnt, 3'd1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
